// File: rtl/mux_ndff_tx.sv
// Source-side launcher for a mux/N-flop synchronizer: registers a word and an enable level toward the crossing.
// Latency: data_tx/en_tx update on the accept edge; fixed mode completes in EN_HOLD+GAP+1 cycles, ack mode on ack_s fall.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while a transfer is in flight.
//
// Ports:
//   clk, rstn          source clock, async active-low reset
//   in_data/in_valid   word offered by the source domain; in_ready = IDLE
//   ack_async          receiver acknowledge level (used only when USE_ACK != 0)
//   data_tx, en_tx     flop-driven data bus and enable level to the crossing
//   busy, done         not-IDLE flag, one-cycle completion pulse (first IDLE cycle)
module mux_ndff_tx #(
  parameter int WIDTH       = 8,
  parameter int USE_ACK     = 0,
  parameter int EN_HOLD     = 3,
  parameter int GAP         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ack_async,
  output logic [WIDTH-1:0] data_tx,
  output logic             en_tx,
  output logic             busy,
  output logic             done
);

  localparam int CNT_MAX = (EN_HOLD > GAP) ? EN_HOLD : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(EN_HOLD - 1);
  // GAP=0 skips the GAP state entirely, so its load value is irrelevant there.
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_GAP,
    S_REQ,
    S_DROP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]       r_data, w_data_nxt;
  logic                   r_en, w_en_nxt;
  logic                   r_done, w_done_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   w_ack_s;
  logic                   w_accept;

  // Acknowledge synchronizer; bit 0 is the first stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
    end
  end

  assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
  assign w_accept = in_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Data only ever loads here, so it is stable whenever en_tx is high.
        if (w_accept) begin
          w_data_nxt  = in_data;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = (USE_ACK != 0) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_en_nxt = 1'b0;
          if (GAP > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LD;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_REQ: begin
        if (w_ack_s) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (!w_ack_s) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign data_tx  = r_data;
  assign en_tx    = r_en;
  assign done     = r_done;

endmodule

// File: tb/tb_mux_ndff_tx.sv
// Bench for mux_ndff_tx: two fixed-interval instances (3/2 and 1/0) plus one ack-mode instance.
// Expected outputs come from an edge-indexed timing model of each transfer.
module tb_mux_ndff_tx;

  localparam int BIG  = 100000000;
  localparam int A_SS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn = 1'b0;
  logic       tie0 = 1'b0;
  logic       f_valid = 1'b0;
  logic [7:0] f_data = '0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = '0;
  logic       a_ack = 1'b0;

  logic       f0_ready, f0_en, f0_busy, f0_done;
  logic [7:0] f0_dat;
  logic       f1_ready, f1_en, f1_busy, f1_done;
  logic [7:0] f1_dat;
  logic       a_ready, a_en, a_busy_o, a_done;
  logic [7:0] a_dat;

  mux_ndff_tx #(.WIDTH(8), .USE_ACK(0), .EN_HOLD(3), .GAP(2), .SYNC_STAGES(2)) u_fix (
    .clk(clk), .rstn(rstn), .in_data(f_data), .in_valid(f_valid), .in_ready(f0_ready),
    .ack_async(tie0), .data_tx(f0_dat), .en_tx(f0_en), .busy(f0_busy), .done(f0_done));

  mux_ndff_tx #(.WIDTH(8), .USE_ACK(0), .EN_HOLD(1), .GAP(0), .SYNC_STAGES(2)) u_fix0 (
    .clk(clk), .rstn(rstn), .in_data(f_data), .in_valid(f_valid), .in_ready(f1_ready),
    .ack_async(tie0), .data_tx(f1_dat), .en_tx(f1_en), .busy(f1_busy), .done(f1_done));

  mux_ndff_tx #(.WIDTH(8), .USE_ACK(1), .EN_HOLD(3), .GAP(2), .SYNC_STAGES(A_SS)) u_ack (
    .clk(clk), .rstn(rstn), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .ack_async(a_ack), .data_tx(a_dat), .en_tx(a_en), .busy(a_busy_o), .done(a_done));

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;   // posedges since modelling started

  // Fixed-mode model: last accept edge and word per instance.
  int       eh[2] = '{3, 1};
  int       gp[2] = '{2, 0};
  int       t_acc[2];
  logic [7:0] wd[2];
  bit       has[2];
  bit       acc0;

  // Ack-mode model: accept edge, first edges sampling ack rise / fall.
  bit         ha;
  logic [7:0] wa;
  int         ar, af;
  logic       aa_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, e, obs, exp);
    end
  endtask

  function automatic bit f_ready(input int i, input int ee);
    return !has[i] || (ee >= t_acc[i] + eh[i] + gp[i]);
  endfunction

  function automatic bit a_busy(input int ee);
    return ha && (ee < af + A_SS);
  endfunction

  task automatic chk_fix(input int i, input logic rdy, input logic [7:0] dat, input logic en,
                         input logic bsy, input logic dn);
    bit x_rdy, x_en, x_dn;
    logic [7:0] x_dat;
    x_rdy = f_ready(i, e);
    x_en  = has[i] && (e >= t_acc[i]) && (e <= t_acc[i] + eh[i] - 1);
    x_dn  = has[i] && (e == t_acc[i] + eh[i] + gp[i]);
    x_dat = has[i] ? wd[i] : 8'h00;
    chk($sformatf("f%0d_ready", i), rdy, x_rdy);
    chk($sformatf("f%0d_busy", i), bsy, !x_rdy);
    chk($sformatf("f%0d_en", i), en, x_en);
    chk($sformatf("f%0d_done", i), dn, x_dn);
    chk($sformatf("f%0d_data", i), dat, x_dat);
  endtask

  task automatic chk_ack();
    bit xb;
    xb = a_busy(e);
    chk("a_ready", a_ready, !xb);
    chk("a_busy", a_busy_o, xb);
    chk("a_en", a_en, ha && (e < ar + A_SS) && (e < af + A_SS));
    chk("a_done", a_done, ha && (e == af + A_SS));
    chk("a_data", a_dat, ha ? wa : 8'h00);
  endtask

  // Apply inputs for the next edge, advance the model, then check after that edge.
  task automatic cyc(input logic fv, input logic [7:0] fd, input logic av, input logic [7:0] ad,
                     input logic aa);
    acc0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (fv && rstn && f_ready(i, e)) begin
        has[i]   = 1'b1;
        t_acc[i] = e + 1;
        wd[i]    = fd;
        if (i == 0) acc0 = 1'b1;
      end
    end
    if (av && rstn && !a_busy(e)) begin
      ha = 1'b1; wa = ad; ar = BIG; af = BIG;
    end
    if (aa && !aa_prev && a_busy(e) && ar == BIG) ar = e + 1;
    if (!aa && aa_prev && ar != BIG && af == BIG) af = e + 1;
    aa_prev = aa;
    f_valid = fv; f_data = fd; a_valid = av; a_data = ad; a_ack = aa;
    @(posedge clk);
    e++;
    @(negedge clk);
    chk_fix(0, f0_ready, f0_dat, f0_en, f0_busy, f0_done);
    chk_fix(1, f1_ready, f1_dat, f1_en, f1_busy, f1_done);
    chk_ack();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has[i] = 1'b0; t_acc[i] = 0; wd[i] = 8'h00;
    end
    ha = 1'b0; wa = 8'h00; ar = BIG; af = BIG; aa_prev = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] b2b_w [3];
  int         idx, prev_acc, ndone, d1, h;
  bit         dut_acc;
  logic [7:0] w;

  initial begin
    model_reset();
    b2b_w[0] = 8'h11; b2b_w[1] = 8'h22; b2b_w[2] = 8'h33;

    // Reset state, observed while reset is asserted.
    repeat (2) @(negedge clk);
    chk("rst_ready", f0_ready, 1'b1);
    chk("rst_en", f0_en, 1'b0);
    chk("rst_data", f0_dat, 8'h00);
    chk("rst_busy", f0_busy, 1'b0);
    chk("rst_done", f0_done, 1'b0);
    chk("rst_a_ready", a_ready, 1'b1);
    rstn = 1'b1;
    idle(2);

    // Single transfers: 0xA5 then 0x7E.
    cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    idle(8);
    cyc(1'b1, 8'h7E, 1'b0, 8'h00, 1'b0);
    idle(8);

    // Back-to-back with in_valid held.
    idx = 0; prev_acc = -1; ndone = 0;
    for (int k = 0; k < 30; k++) begin
      dut_acc = (idx < 3) && f0_ready;
      cyc(idx < 3, b2b_w[(idx < 3) ? idx : 2], 1'b0, 8'h00, 1'b0);
      if (dut_acc) begin
        if (prev_acc >= 0) chk("b2b_period", e - prev_acc, 6);
        prev_acc = e;
      end
      if (f0_done) ndone++;
      if (acc0) idx++;
    end
    chk("b2b_done_cnt", ndone, 3);

    // in_valid pulsed with 0xFF while u_fix is in HOLD.
    cyc(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
    idle(8);

    // Reset in the middle of HOLD.
    cyc(1'b1, 8'hC3, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_en", f0_en, 1'b0);
    chk("midrst_data", f0_dat, 8'h00);
    chk("midrst_busy", f0_busy, 1'b0);
    chk("midrst_ready", f0_ready, 1'b1);
    model_reset();
    idle(2);
    rstn = 1'b1;
    cyc(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    idle(8);

    // Ack mode: first transfer 0x3C with ack raised 5 cycles later, then randomized ones.
    for (int n = 0; n < 4; n++) begin
      w  = (n == 0) ? 8'h3C : 8'($urandom_range(0, 255));
      d1 = (n == 0) ? 5 : int'($urandom_range(1, 6));
      h  = int'($urandom_range(3, 8));
      cyc(1'b0, 8'h00, 1'b1, w, 1'b0);
      for (int k = 0; k < d1 - 1; k++) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), 8'hFF, 1'b0);
      for (int k = 0; k < h; k++) cyc(1'b0, 8'h00, 1'($urandom_range(0, 1)), 8'hFF, 1'b1);
      for (int k = 0; k < 6; k++) cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      // Stray acknowledge pulse while idle.
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      idle(5);
    end

    // Randomized traffic on the fixed-mode instances.
    for (int k = 0; k < 300; k++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0);
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_ndff_tx.md
# mux_ndff_tx

Source-side launcher for the mux/N-flop data synchronizer: accepts a word from the sending clock domain over a valid/ready handshake, drives a glitch-free registered data bus and enable level across the crossing, and holds the data stable until the receiver can safely capture it. It sits at the boundary of the source domain, and its `data_tx`/`en_tx` outputs feed the receiving domain's mux synchronizer directly. Two pacing modes are supported:

- fixed-interval, open loop;
- 4-phase, closed loop on an acknowledge returned from the receiving domain.

## Interface
- `WIDTH`, 8: data width.
- `USE_ACK`, 0: 0 = fixed-interval pacing; 1 = 4-phase handshake on `ack_async`.
- `EN_HOLD`, 3: cycles `en_tx` stays high per transfer in fixed mode; must be ≥1.
- `GAP`, 2: cycles `en_tx` stays low after the hold, with data still held, in fixed mode; must be ≥0.
- `SYNC_STAGES`, 2: flop stages synchronizing `ack_async`; must be ≥2.
- `clk` input 1: source-domain clock; all logic on its rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `in_data` input `WIDTH`: word to transfer.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a word; high only in IDLE.
- `ack_async` input 1: acknowledge level from the receiving domain; ignored when `USE_ACK`=0.
- `data_tx` output `WIDTH`: registered data to the crossing.
- `en_tx` output 1: registered enable level to the crossing.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when a transfer completes.

## Operation
- **States:** IDLE, HOLD, GAP (fixed mode); IDLE, REQ, DROP (ack mode).
- **Accept:** a word is accepted when `in_valid` and `in_ready` are both high.
  - On accept, `in_data` loads `data_tx` and `en_tx` is set to 1 on the same edge.
  - The FSM then goes to HOLD (fixed mode) or REQ (ack mode).
- **Registered outputs:** `data_tx` and `en_tx` are flop outputs only, with no combinational path to the crossing.
- **Data hold:** `data_tx` changes only on accept. It holds its value through HOLD/GAP/REQ/DROP and in IDLE until the next accept.
- **Fixed mode:**
  - A down-counter is loaded with `EN_HOLD-1` on accept.
  - HOLD decrements the counter each cycle. At 0, `en_tx` is set to 0.
    - If `GAP`>0: go to GAP with the counter loaded to `GAP-1`.
    - If `GAP`=0: go to IDLE with `done`=1.
  - GAP decrements the counter each cycle. At 0: go to IDLE and `done`=1.
- **Ack mode:**
  - `ack_async` passes through `SYNC_STAGES` flops (reset 0) to give `ack_s`.
  - REQ holds `en_tx`=1 until `ack_s`=1, then clears `en_tx` and goes to DROP.
  - DROP waits for `ack_s`=0, then goes to IDLE with `done`=1.
  - No timeout: a missing ack stalls the block in REQ or DROP indefinitely.
- **Counter width:** `$clog2(max(EN_HOLD,GAP)+1)` bits. The counter is never decremented below 0.
- **Input outside IDLE:** `in_valid` is ignored outside IDLE; `in_ready`=0 there.
- **Stray ack:** `ack_s` toggling while in IDLE has no effect.
- **Reset:**
  - Reset (asserted at any time, including mid-transfer) forces the state to IDLE.
  - Reset values: `data_tx`=0, `en_tx`=0, `busy`=0, `done`=0, counter=0, ack sync flops=0.
  - `in_ready` reads 1 while in IDLE, including during reset.

## Timing
- **Fixed mode, accept at edge T:**
  - `en_tx`=1 and `data_tx` valid for cycles T+1 … T+`EN_HOLD`.
  - `en_tx`=0 for cycles T+`EN_HOLD`+1 … T+`EN_HOLD`+`GAP`.
  - `done` pulses, and `in_ready` rises, in cycle T+`EN_HOLD`+`GAP`+1. `done` coincides with the first IDLE cycle.
  - A back-to-back accept is possible in that same cycle.
  - Peak throughput: 1 word per `EN_HOLD`+`GAP`+1 cycles.
- **Ack mode:**
  - `ack_async` rising at edge A is seen at `ack_s` on edge A+`SYNC_STAGES`.
  - `en_tx` falls one edge after that.
  - The return to IDLE follows by the same latency after `ack_async` falls.
- **Data timing:** `data_tx` is never updated in a cycle where `en_tx` is 1.
  - The receiver requirement is `EN_HOLD` ≥ its synchronizer depth + 1.
  - The receiver requirement is `GAP` ≥ its synchronizer depth.

## Test plan
- **Fixed mode, single transfer** (`WIDTH`=8, `EN_HOLD`=3, `GAP`=2): accept 0xA5 at T.
  - `data_tx`=0xA5 from T+1.
  - `en_tx`=1 at T+1..T+3 and 0 at T+4..T+5.
  - `done`=1 and `in_ready`=1 at T+6.
- **Back-to-back with held `in_valid`** (same config): words 0x11, 0x22, 0x33.
  - Accepts occur every 6 cycles.
  - `data_tx` never changes while `en_tx`=1.
  - Exactly 3 `done` pulses.
- **`GAP`=0, `EN_HOLD`=1:** accept 0x7E at T.
  - `en_tx`=1 only at T+1.
  - `done` and `in_ready` at T+2.
- **Ack mode** (`SYNC_STAGES`=2): accept 0x3C, raise `ack_async` 5 cycles later.
  - `en_tx` falls 3 edges after the `ack_async` rise.
  - Drop `ack_async`: `done` fires 3 edges later.
  - `data_tx`=0x3C throughout.
- **Reset mid-HOLD:** assert `rstn`=0 at T+2 of a transfer.
  - Immediately `en_tx`=0, `data_tx`=0x00, `busy`=0.
  - After release, the next accept behaves as in the fixed-mode single-transfer case.
- **`in_valid` while busy:** pulse `in_valid` with 0xFF during HOLD.
  - Not accepted.
  - `data_tx` unchanged.
  - No extra `done` pulse.
